// File: rtl/squeeze_ctrl.sv
// squeeze_ctrl: squeeze-phase sequencer driving squeeze_unit offsets and the output stream handshake
module squeeze_ctrl #(
   parameter int OUT_BYTES      = 32,
   parameter int CNT_WIDTH      = 8,
   parameter int LEN_WIDTH      = 16,
   parameter int MODE_SEL_WIDTH = 2,
   parameter int RATE_WIDTH     = 11
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start_i,
   input  logic [MODE_SEL_WIDTH-1:0] keccak_mode_i,
   input  logic [RATE_WIDTH-1:0]     rate_i,
   input  logic [LEN_WIDTH-1:0]      out_len_i,
   output logic [CNT_WIDTH-1:0]      bytes_squeezed_o,
   output logic                      perm_start_o,
   input  logic                      perm_done_i,
   output logic                      m_valid_o,
   input  logic                      m_ready_i,
   output logic [OUT_BYTES-1:0]      m_keep_o,
   output logic                      m_last_o,
   output logic                      busy_o,
   output logic                      done_o
);
   localparam logic [MODE_SEL_WIDTH-1:0] SHA3_256 = MODE_SEL_WIDTH'(0);
   localparam logic [MODE_SEL_WIDTH-1:0] SHA3_512 = MODE_SEL_WIDTH'(1);
   localparam logic [LEN_WIDTH-1:0] OB_L = LEN_WIDTH'(OUT_BYTES);
   localparam logic [CNT_WIDTH-1:0] OB_C = CNT_WIDTH'(OUT_BYTES);

   typedef enum logic [1:0] {IDLE, STREAM, PERM} state_t;

   state_t               state_q;
   logic [CNT_WIDTH-1:0] rate_bytes_q, cnt_q, rate_rem;
   logic [LEN_WIDTH-1:0] rem_q, eff_len, m1, n;
   logic                 valid_q, busy_q, perm_q, done_q, stream;

   // Beat sizing and stream sidebands, derived from registered state only
   always_comb begin
      eff_len  = keccak_mode_i == SHA3_256 ? LEN_WIDTH'(32) :
                 keccak_mode_i == SHA3_512 ? LEN_WIDTH'(64) : out_len_i;
      rate_rem = rate_bytes_q - cnt_q;
      m1       = LEN_WIDTH'(rate_rem) < rem_q ? LEN_WIDTH'(rate_rem) : rem_q;
      n        = m1 < OB_L ? m1 : OB_L;
      stream   = state_q == STREAM;
      m_keep_o = stream ? ~({OUT_BYTES{1'b1}} << n) : '0;
      m_last_o = stream && rem_q <= n;
   end

   assign bytes_squeezed_o = cnt_q;
   assign m_valid_o        = valid_q;
   assign busy_o           = busy_q;
   assign perm_start_o     = perm_q;
   assign done_o           = done_q;

   // Squeeze FSM with registered valid/busy/pulse outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         rate_bytes_q <= '0;
         cnt_q        <= '0;
         rem_q        <= '0;
         valid_q      <= 1'b0;
         busy_q       <= 1'b0;
         perm_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         perm_q <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (start_i) begin
               if (eff_len == '0) done_q <= 1'b1;
               else begin
                  rate_bytes_q <= CNT_WIDTH'(rate_i >> 3);
                  cnt_q        <= '0;
                  rem_q        <= eff_len;
                  state_q      <= STREAM;
                  valid_q      <= 1'b1;
                  busy_q       <= 1'b1;
               end
            end
            STREAM: if (m_ready_i) begin
               if (m_last_o) begin
                  state_q <= IDLE;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  cnt_q   <= '0;
                  rem_q   <= '0;
               end else if (rate_rem <= OB_C) begin
                  state_q <= PERM;
                  valid_q <= 1'b0;
                  perm_q  <= 1'b1;
                  cnt_q   <= '0;
                  rem_q   <= rem_q - n;
               end else begin
                  cnt_q <= cnt_q + OB_C;
                  rem_q <= rem_q - n;
               end
            end
            PERM: if (perm_done_i) begin
               state_q <= STREAM;
               valid_q <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_squeeze_ctrl.sv
// tb_squeeze_ctrl: table-driven, hand-sequenced and randomized checks of squeeze_ctrl
module tb_squeeze_ctrl;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0, perm_done = 1'b0, m_ready = 1'b0;
   logic [1:0]  mode = '0;
   logic [10:0] rate = '0;
   logic [15:0] out_len = '0;
   logic [7:0]  bsq;
   logic [31:0] keep;
   logic        perm_start, m_valid, m_last, busy, done;
   int          errors = 0, checks = 0;

   squeeze_ctrl dut (
      .clk(clk), .rst(rst), .start_i(start), .keccak_mode_i(mode), .rate_i(rate),
      .out_len_i(out_len), .bytes_squeezed_o(bsq), .perm_start_o(perm_start),
      .perm_done_i(perm_done), .m_valid_o(m_valid), .m_ready_i(m_ready),
      .m_keep_o(keep), .m_last_o(m_last), .busy_o(busy), .done_o(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic idle_chk(input string nm);
      chk({nm, " valid"}, 32'(m_valid), 0);
      chk({nm, " keep"}, keep, 0);
      chk({nm, " last"}, 32'(m_last), 0);
      chk({nm, " perm_start"}, 32'(perm_start), 0);
      chk({nm, " offset"}, 32'(bsq), 0);
      chk({nm, " busy"}, 32'(busy), 0);
   endtask

   typedef struct { int off; int n; bit last; bit perm; } beat_t;

   // Runs one squeeze job; expected beats come from a byte-level walk over the rate
   task automatic run_job(input logic [1:0] md, input logic [10:0] rt, input logic [15:0] ln,
                          input bit rnd, output int nb, output int np);
      beat_t q[$];
      beat_t b;
      int rb, pos, remn, len_eff, g;
      bit acc;
      logic [63:0] one = 64'd1;
      rb = int'(rt) / 8;
      len_eff = md == 0 ? 32 : md == 1 ? 64 : int'(ln);
      pos = 0;
      remn = len_eff;
      while (remn > 0) begin
         b.off = pos;
         b.n = rb - pos;
         if (remn < b.n) b.n = remn;
         if (b.n > 32) b.n = 32;
         b.last = b.n == remn;
         remn -= b.n;
         pos += b.n;
         b.perm = pos == rb && !b.last;
         if (b.perm) pos = 0;
         q.push_back(b);
      end
      nb = 0;
      np = 0;
      start = 1; mode = md; rate = rt; out_len = ln;
      @(negedge clk);
      start = 0;
      if (len_eff == 0) begin
         chk("zero-len done", 32'(done), 1);
         idle_chk("zero-len");
         @(negedge clk);
         chk("zero-len done drop", 32'(done), 0);
         chk("zero-len valid", 32'(m_valid), 0);
         return;
      end
      foreach (q[i]) begin
         g = 0;
         do begin
            chk("beat valid", 32'(m_valid), 1);
            chk("beat busy", 32'(busy), 1);
            chk("beat offset", 32'(bsq), 32'(q[i].off));
            chk("beat keep", keep, 32'((one << q[i].n) - 1));
            chk("beat last", 32'(m_last), 32'(q[i].last));
            chk("beat perm_start", 32'(perm_start), 0);
            chk("beat done", 32'(done), 0);
            acc = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            m_ready = acc;
            perm_done = rnd && $urandom_range(0, 7) == 0;
            if (acc && m_valid) nb++;
            @(negedge clk);
            g++;
         end while (!acc && g < 64);
         m_ready = 0;
         perm_done = 0;
         if (!acc) begin
            chk("accept timeout", 0, 1);
            return;
         end
         if (q[i].last) begin
            chk("end done", 32'(done), 1);
            chk("end perm_start", 32'(perm_start), 0);
            idle_chk("end");
            @(negedge clk);
            chk("end done drop", 32'(done), 0);
         end else if (q[i].perm) begin
            chk("perm pulse", 32'(perm_start), 1);
            chk("perm valid", 32'(m_valid), 0);
            chk("perm busy", 32'(busy), 1);
            np += int'(perm_start);
            repeat ($urandom_range(0, 3)) begin
               @(negedge clk);
               chk("perm one-shot", 32'(perm_start), 0);
               chk("perm wait valid", 32'(m_valid), 0);
            end
            perm_done = 1;
            @(negedge clk);
            perm_done = 0;
         end
      end
   endtask

   typedef struct { logic [1:0] md; logic [10:0] rt; logic [15:0] ln; bit rnd; int eb; int ep; } vec_t;
   vec_t tbl[8];
   logic [10:0] rates[4] = '{11'd1344, 11'd1088, 11'd832, 11'd576};

   initial begin
      int nb, np;
      tbl[0] = '{2'd0, 11'd1088, 16'd0,   1'b0, 1,  0};
      tbl[1] = '{2'd1, 11'd576,  16'd0,   1'b1, 2,  0};
      tbl[2] = '{2'd2, 11'd1344, 16'd200, 1'b0, 7,  1};
      tbl[3] = '{2'd3, 11'd1088, 16'd136, 1'b0, 5,  0};
      tbl[4] = '{2'd3, 11'd1088, 16'd0,   1'b0, 0,  0};
      tbl[5] = '{2'd2, 11'd1344, 16'd40,  1'b0, 2,  0};
      tbl[6] = '{2'd3, 11'd1088, 16'd300, 1'b1, 11, 2};
      tbl[7] = '{2'd2, 11'd1344, 16'd200, 1'b1, 7,  1};
      repeat (2) @(negedge clk);
      idle_chk("reset");
      chk("reset done", 32'(done), 0);
      rst = 0;
      @(negedge clk);
      idle_chk("post-reset");
      foreach (tbl[i]) begin
         run_job(tbl[i].md, tbl[i].rt, tbl[i].ln, tbl[i].rnd, nb, np);
         chk("table beats", 32'(nb), 32'(tbl[i].eb));
         chk("table perms", 32'(np), 32'(tbl[i].ep));
      end
      // reset while waiting on a permutation, late perm_done must be ignored
      start = 1; mode = 2; rate = 1344; out_len = 200;
      @(negedge clk);
      start = 0;
      m_ready = 1;
      repeat (6) @(negedge clk);
      m_ready = 0;
      chk("pre-reset perm", 32'(perm_start), 1);
      rst = 1;
      @(negedge clk);
      rst = 0;
      idle_chk("mid-perm reset");
      perm_done = 1;
      @(negedge clk);
      perm_done = 0;
      idle_chk("late perm_done");
      @(negedge clk);
      idle_chk("late perm_done hold");
      chk("late perm_done done", 32'(done), 0);
      // start during STREAM is ignored, outputs hold through a stall
      start = 1; mode = 1; rate = 576; out_len = 0;
      @(negedge clk);
      start = 1; mode = 3; rate = 1344; out_len = 0;
      @(negedge clk);
      start = 0;
      chk("restart valid", 32'(m_valid), 1);
      chk("restart offset", 32'(bsq), 0);
      chk("restart keep", keep, 32'hFFFF_FFFF);
      chk("restart last", 32'(m_last), 0);
      chk("restart done", 32'(done), 0);
      m_ready = 1;
      @(negedge clk);
      chk("beat2 offset", 32'(bsq), 32);
      chk("beat2 keep", keep, 32'hFFFF_FFFF);
      chk("beat2 last", 32'(m_last), 1);
      @(negedge clk);
      m_ready = 0;
      chk("beat2 done", 32'(done), 1);
      idle_chk("beat2 end");
      @(negedge clk);
      // randomized jobs against the byte-walk model
      repeat (20) begin
         run_job(2'($urandom_range(0, 3)), rates[$urandom_range(0, 3)],
                 16'($urandom_range(0, 400)), 1'b1, nb, np);
         @(negedge clk);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
